// File: rtl/edit_mode_controller.sv
// Key-driven screen/edit-position controller with idle timeout and blink for the edited digit.
// Raw active-low keys are synchronized and reduced to one-cycle press events.
module edit_mode_controller #(
    parameter int unsigned NUM_SCREENS = 4,
    parameter int unsigned POS_MAX     = 7,
    parameter int unsigned TZ_SCREEN   = 2,
    parameter int unsigned TZ_POS_MAX  = 2,
    parameter int unsigned TIMEOUT     = 50_000_000,
    parameter int unsigned BLINK_DIV   = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       KeyMode,
    input  logic       KeyEdit,
    input  logic       KeyNext,
    input  logic       KeyPlus,
    input  logic       KeyMinus,
    output logic [1:0] screen,
    output logic       EditMode,
    output logic [2:0] EditPos,
    output logic       Blink
);

    localparam int unsigned TW = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {VIEW, EDIT} state_t;

    logic [4:0] key_raw, sync1, sync2, prev, ev;
    logic       ev_mode, ev_edit, ev_next, ev_any;

    state_t        state, state_n;
    logic [1:0]    screen_q, screen_n;
    logic [2:0]    pos_q, pos_n, pmax;
    logic [TW-1:0] idle_q, idle_n;
    logic [BW-1:0] div_q, div_n;
    logic          blink_q, blink_n;

    assign key_raw = {KeyMinus, KeyPlus, KeyNext, KeyEdit, KeyMode};

    // Released-key level is 1, so reset to 1 to avoid a spurious press on release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign ev      = prev & ~sync2;
    assign ev_mode = ev[0];
    assign ev_edit = ev[1];
    assign ev_next = ev[2];
    assign ev_any  = |ev;

    assign pmax = (screen_q == 2'(TZ_SCREEN)) ? 3'(TZ_POS_MAX) : 3'(POS_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= VIEW;
            screen_q <= '0;
            pos_q    <= '0;
            idle_q   <= '0;
            div_q    <= '0;
            blink_q  <= 1'b1;
        end else begin
            state    <= state_n;
            screen_q <= screen_n;
            pos_q    <= pos_n;
            idle_q   <= idle_n;
            div_q    <= div_n;
            blink_q  <= blink_n;
        end
    end

    always_comb begin
        state_n  = state;
        screen_n = screen_q;
        pos_n    = pos_q;
        idle_n   = '0;
        div_n    = '0;
        blink_n  = 1'b1;
        case (state)
            VIEW: begin
                if (ev_edit) begin
                    state_n = EDIT;
                    pos_n   = '0;
                end else if (ev_mode) begin
                    screen_n = (screen_q == 2'(NUM_SCREENS - 1)) ? '0 : screen_q + 2'd1;
                end
            end
            EDIT: begin
                idle_n = idle_q + TW'(1);
                if (div_q == BW'(BLINK_DIV - 1)) begin
                    div_n   = '0;
                    blink_n = ~blink_q;
                end else begin
                    div_n   = div_q + BW'(1);
                    blink_n = blink_q;
                end
                // Any key event outranks the timeout expiring in the same cycle
                if (ev_edit) begin
                    state_n = VIEW;
                    pos_n   = '0;
                    idle_n  = '0;
                    div_n   = '0;
                    blink_n = 1'b1;
                end else if (ev_next) begin
                    pos_n   = (pos_q == pmax) ? '0 : pos_q + 3'd1;
                    idle_n  = '0;
                    div_n   = '0;
                    blink_n = 1'b1;
                end else if (ev_any) begin
                    idle_n = '0;
                end else if (idle_q == TW'(TIMEOUT - 1)) begin
                    state_n = VIEW;
                    pos_n   = '0;
                    idle_n  = '0;
                    div_n   = '0;
                    blink_n = 1'b1;
                end
            end
            default: state_n = VIEW;
        endcase
    end

    assign screen   = screen_q;
    assign EditMode = (state == EDIT);
    assign EditPos  = pos_q;
    assign Blink    = blink_q;

endmodule

// File: tb/tb_edit_mode_controller.sv
// Self-checking bench for edit_mode_controller: press table with scoreboard plus timing sequences.
module tb_edit_mode_controller;

    localparam logic [4:0] K_MODE  = 5'b00001;
    localparam logic [4:0] K_EDIT  = 5'b00010;
    localparam logic [4:0] K_NEXT  = 5'b00100;
    localparam logic [4:0] K_PLUS  = 5'b01000;
    localparam logic [4:0] K_MINUS = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       KeyMode, KeyEdit, KeyNext, KeyPlus, KeyMinus;
    logic [1:0] screen;
    logic       EditMode;
    logic [2:0] EditPos;
    logic       Blink;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] keys;
        logic [1:0] scr;
        logic       em;
        logic [2:0] pos;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    edit_mode_controller #(
        .NUM_SCREENS(4),
        .POS_MAX(7),
        .TZ_SCREEN(2),
        .TZ_POS_MAX(2),
        .TIMEOUT(20),
        .BLINK_DIV(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .KeyMode(KeyMode),
        .KeyEdit(KeyEdit),
        .KeyNext(KeyNext),
        .KeyPlus(KeyPlus),
        .KeyMinus(KeyMinus),
        .screen(screen),
        .EditMode(EditMode),
        .EditPos(EditPos),
        .Blink(Blink)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_keys(input logic [4:0] mask);
        {KeyMinus, KeyPlus, KeyNext, KeyEdit, KeyMode} = ~mask;
    endtask

    // Outputs settle on the third edge; sampled after the fourth
    task automatic press(input logic [4:0] mask);
        drive_keys(mask);
        tick();
        tick();
        drive_keys('0);
        tick();
        tick();
    endtask

    // Returns at the negedge right after the edge that enters EDIT
    task automatic enter_edit(input string tag);
        drive_keys(K_EDIT);
        tick();
        tick();
        drive_keys('0);
        tick();
        chk({tag, ".entry_em"}, int'(EditMode), 1);
        chk({tag, ".entry_blink"}, int'(Blink), 1);
    endtask

    initial begin
        vec_t v;
        vec_t e;

        tbl.push_back('{K_MODE, 2'd1, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd2, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd3, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd0, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd1, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd2, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd3, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd0, 1'b0, 3'd0});
        tbl.push_back('{K_EDIT, 2'd0, 1'b1, 3'd0});
        for (int p = 1; p <= 8; p++)
            tbl.push_back('{K_NEXT, 2'd0, 1'b1, 3'(p % 8)});
        tbl.push_back('{K_EDIT, 2'd0, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd1, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd2, 1'b0, 3'd0});
        tbl.push_back('{K_EDIT, 2'd2, 1'b1, 3'd0});
        tbl.push_back('{K_NEXT, 2'd2, 1'b1, 3'd1});
        tbl.push_back('{K_NEXT, 2'd2, 1'b1, 3'd2});
        tbl.push_back('{K_NEXT, 2'd2, 1'b1, 3'd0});
        tbl.push_back('{K_MODE, 2'd2, 1'b1, 3'd0});
        tbl.push_back('{K_NEXT, 2'd2, 1'b1, 3'd1});
        tbl.push_back('{K_EDIT | K_NEXT, 2'd2, 1'b0, 3'd0});
        tbl.push_back('{K_EDIT | K_MODE, 2'd2, 1'b1, 3'd0});
        tbl.push_back('{K_NEXT | K_MODE, 2'd2, 1'b1, 3'd1});
        tbl.push_back('{K_PLUS, 2'd2, 1'b1, 3'd1});
        tbl.push_back('{K_MINUS, 2'd2, 1'b1, 3'd1});
        tbl.push_back('{K_EDIT, 2'd2, 1'b0, 3'd0});
        tbl.push_back('{K_NEXT, 2'd2, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd3, 1'b0, 3'd0});
        tbl.push_back('{K_MODE, 2'd0, 1'b0, 3'd0});

        reset = 1'b0;
        drive_keys('0);
        tick();
        tick();
        chk("rst.screen", int'(screen), 0);
        chk("rst.em", int'(EditMode), 0);
        chk("rst.pos", int'(EditPos), 0);
        chk("rst.blink", int'(Blink), 1);
        reset = 1'b1;
        tick();
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            press(v.keys);
            sb.push_back(v);
            e = sb.pop_front();
            chk($sformatf("step%0d.screen", i), int'(screen), int'(e.scr));
            chk($sformatf("step%0d.em", i), int'(EditMode), int'(e.em));
            chk($sformatf("step%0d.pos", i), int'(EditPos), int'(e.pos));
            if (!e.em || (e.keys & (K_EDIT | K_NEXT)) != '0)
                chk($sformatf("step%0d.blink", i), int'(Blink), 1);
        end

        // Long KeyNext hold; KeyPlus taps keep the idle timer from expiring
        enter_edit("hold");
        KeyNext = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 10 == 5) KeyPlus = 1'b0;
            if (i % 10 == 7) KeyPlus = 1'b1;
            if (i % 10 == 9) begin
                chk($sformatf("hold%0d.pos", i), int'(EditPos), 1);
                chk($sformatf("hold%0d.em", i), int'(EditMode), 1);
            end
        end
        KeyNext = 1'b1;
        tick();
        tick();
        tick();
        chk("hold.release_pos", int'(EditPos), 1);
        press(K_EDIT);
        chk("hold.exit_em", int'(EditMode), 0);

        // Plain timeout with blink waveform
        enter_edit("tmo");
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k < 20) begin
                chk($sformatf("tmo%0d.em", k), int'(EditMode), 1);
                chk($sformatf("tmo%0d.blink", k), int'(Blink), ((k / 4) % 2 == 0) ? 1 : 0);
            end else begin
                chk("tmo.exit_em", int'(EditMode), 0);
                chk("tmo.exit_pos", int'(EditPos), 0);
                chk("tmo.exit_blink", int'(Blink), 1);
            end
        end

        // KeyPlus activity restarts the idle count
        enter_edit("tmo_plus");
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 12) KeyPlus = 1'b0;
            if (k == 14) KeyPlus = 1'b1;
            if (k == 30 || k == 34)
                chk($sformatf("tmo_plus%0d.em", k), int'(EditMode), 1);
            if (k == 35)
                chk("tmo_plus35.em", int'(EditMode), 0);
        end

        // Asynchronous reset in the middle of an edit
        press(K_MODE);
        chk("arst.pre_screen", int'(screen), 1);
        enter_edit("arst");
        press(K_NEXT);
        chk("arst.pre_pos", int'(EditPos), 1);
        tick();
        reset = 1'b0;
        #1;
        chk("arst.screen", int'(screen), 0);
        chk("arst.em", int'(EditMode), 0);
        chk("arst.pos", int'(EditPos), 0);
        chk("arst.blink", int'(Blink), 1);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("arst.after_screen", int'(screen), 0);
        chk("arst.after_em", int'(EditMode), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
